rom_burst_reader: RTL and testbench
===================================

// Module: rom_burst_reader
// PURPOSE
//  Read-side counterpart of the ROM loader: serves game-side ROM fetches from SDRAM regions the loader filled.
//  Accepts word reads from one client (CPU or video fetch), keeps one BURST-word line cached and refills it
//  from the SDRAM controller on a miss. Sits between one client port and one SDRAM controller read channel.
// PARAMETERS
//  BASE_ADDR  25'h0  SDRAM byte base of the region; added to every client address
//  BURST      4      words per line/refill; power of two, 2..8
// PORTS
//  sys_clk    in   1   single clock for all logic
//  reset_n    in   1   synchronous active-low reset
//  rd_req     in   1   client read request; level, held until rd_ack
//  rd_addr    in   25  client byte address, region-relative; bit 0 ignored (word reads)
//  rd_data    out  16  read word; valid in the rd_ack cycle, held until the next ack
//  rd_ack     out  1   one-cycle pulse: request complete
//  flush      in   1   invalidate cached line (driven while ROM download active)
//  busy       out  1   high while a refill is outstanding
//  sdr_addr   out  25  SDRAM byte address of refill line start
//  sdr_req    out  1   refill request; level, held until first sdr_rdy
//  sdr_rdy    in   1   one pulse per returned word; BURST pulses per refill, in address order
//  sdr_q      in   16  SDRAM word, valid when sdr_rdy
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE, line_valid=0, rd_ack=0, rd_data=0, sdr_req=0, sdr_addr=0, busy=0,
//   word count=0. Reset mid-refill abandons it; later sdr_rdy pulses ignored while in IDLE.
//  Address: full = BASE_ADDR + rd_addr (25-bit, wraps mod 2^25). line tag = full[24:log2(BURST)+1];
//   word index = full[log2(BURST):1]. sdr_addr = {tag, (log2(BURST)+1) zero bits}.
//  States: IDLE, FILL, DONE.
//  IDLE: rd_req=1 and rd_ack=0 and line_valid and tag match -> rd_data<=line[idx], rd_ack<=1 next cycle
//   (hit latency 1). Miss -> sdr_addr<=line start, sdr_req<=1, busy<=1, line_valid<=0, count<=0, -> FILL.
//   rd_req still high in the cycle after an ack is a new request; client drops or changes rd_req after ack.
//  FILL: each sdr_rdy: line[count]<=sdr_q, count++. First sdr_rdy clears sdr_req same edge.
//   On BURST-th word: line_valid<=1, tag latched, busy<=0, -> DONE.
//  DONE: rd_data<=line[idx], rd_ack<=1, -> IDLE. Miss latency = final sdr_rdy cycle + 1.
//  Words arrive in the line regardless of requested index; no critical-word-first.
//  rd_addr must stay stable while rd_req high; rd_ack never asserted without rd_req.
//  flush: line_valid<=0 in any state; in FILL the refill completes (data consumed) but line_valid stays 0
//   if flush seen during FILL; the pending request is still acked with the fetched word.
//  flush and hit-check same cycle: flush wins -> treated as miss.
//  sdr_rdy in IDLE/DONE ignored. rd_req dropped during FILL: refill completes, no rd_ack.
//  rd_ack always exactly one cycle.
// TESTING
//  Cold miss: BURST=4, BASE 0, rd_addr 0x10, SDRAM words 0xA0..0xA3 -> sdr_addr 0x10, sdr_req until 1st rdy,
//   rd_data 0xA0, rd_ack 1 cycle after 4th rdy.
//  Hit: then rd_addr 0x16 -> rd_ack next cycle, rd_data 0xA3, no sdr_req.
//  Miss w/ base: BASE_ADDR 0x100000, rd_addr 0x2A -> sdr_addr 0x100028, rd_data = 2nd returned word.
//  Flush: after fill, pulse flush, re-read 0x10 -> new refill issued (sdr_req rises), data from new burst.
//  Reset mid-FILL: reset_n low after 2 rdy pulses -> sdr_req 0, busy 0; remaining rdy ignored;
//   next read 0x10 refetches.
//  Wrap: BASE 25'h1FFFFF8, rd_addr 0x10 -> sdr_addr 0x0000008.

Source files
------------

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_burst_reader
//  Description : Single-line ROM read cache in front of an SDRAM controller
//                read channel. Word reads hit the cached BURST-word line in
//                one cycle. A miss refills the whole line in address order
//                and acks the request one cycle after the last word arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_burst_reader #(
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter int          BURST     = 4
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic [24:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_ack,
    input  logic        flush,
    output logic        busy,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    input  logic [15:0] sdr_q
);

    localparam int c_IDX_W = $clog2(BURST);
    localparam int c_TAG_W = 24 - c_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state,      w_state_n;
    logic                 r_line_valid, w_line_valid_n;
    logic [c_TAG_W-1:0]   r_tag,        w_tag_n;
    logic [c_IDX_W-1:0]   r_count,      w_count_n;
    logic                 r_flushed,    w_flushed_n;
    logic [15:0]          r_rd_data,    w_rd_data_n;
    logic                 r_rd_ack,     w_rd_ack_n;
    logic                 r_sdr_req,    w_sdr_req_n;
    logic [24:0]          r_sdr_addr,   w_sdr_addr_n;
    logic                 r_busy,       w_busy_n;
    logic [15:0]          r_line [BURST];

    logic                 w_line_we;
    logic [23:0]          w_word;
    logic [c_TAG_W-1:0]   w_tag;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_hit;

    // Region-relative byte address rebased into SDRAM space, kept as a word address
    assign w_word = 24'((BASE_ADDR + rd_addr) >> 1);
    assign w_tag  = w_word[23:c_IDX_W];
    assign w_idx  = w_word[c_IDX_W-1:0];
    // A flush in the same cycle as the lookup forces a miss
    assign w_hit  = r_line_valid && !flush && (w_tag == r_tag);

    // Next-state and registered-output decode
    always_comb begin
        w_state_n      = r_state;
        w_line_valid_n = r_line_valid & ~flush;
        w_tag_n        = r_tag;
        w_count_n      = r_count;
        w_flushed_n    = r_flushed;
        w_rd_data_n    = r_rd_data;
        w_rd_ack_n     = 1'b0;
        w_sdr_req_n    = r_sdr_req;
        w_sdr_addr_n   = r_sdr_addr;
        w_busy_n       = r_busy;
        w_line_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The cycle right after an ack is skipped so a held rd_req is not re-served
                if (rd_req && !r_rd_ack) begin
                    if (w_hit) begin
                        w_rd_data_n = r_line[w_idx];
                        w_rd_ack_n  = 1'b1;
                    end else begin
                        w_sdr_addr_n   = {w_tag, {(c_IDX_W + 1){1'b0}}};
                        w_sdr_req_n    = 1'b1;
                        w_busy_n       = 1'b1;
                        w_line_valid_n = 1'b0;
                        w_count_n      = '0;
                        w_flushed_n    = 1'b0;
                        w_tag_n        = w_tag;
                        w_state_n      = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (flush) begin
                    w_flushed_n = 1'b1;
                end
                if (sdr_rdy) begin
                    w_line_we   = 1'b1;
                    w_count_n   = r_count + 1'b1;
                    w_sdr_req_n = 1'b0;
                    if (r_count == c_IDX_W'(BURST - 1)) begin
                        // Data fetched under a flush is still delivered but not kept as a hit
                        w_line_valid_n = !(r_flushed || flush);
                        w_busy_n       = 1'b0;
                        w_state_n      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
                // Only ack a request that is still asking for the line just fetched
                if (rd_req && (w_tag == r_tag)) begin
                    w_rd_data_n = r_line[w_idx];
                    w_rd_ack_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any refill in flight
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_line_valid <= 1'b0;
            r_tag        <= '0;
            r_count      <= '0;
            r_flushed    <= 1'b0;
            r_rd_data    <= 16'h0;
            r_rd_ack     <= 1'b0;
            r_sdr_req    <= 1'b0;
            r_sdr_addr   <= 25'h0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_line_valid <= w_line_valid_n;
            r_tag        <= w_tag_n;
            r_count      <= w_count_n;
            r_flushed    <= w_flushed_n;
            r_rd_data    <= w_rd_data_n;
            r_rd_ack     <= w_rd_ack_n;
            r_sdr_req    <= w_sdr_req_n;
            r_sdr_addr   <= w_sdr_addr_n;
            r_busy       <= w_busy_n;
        end
    end

    // Line storage; contents are meaningless until line_valid so no reset is needed
    always_ff @(posedge sys_clk) begin
        if (w_line_we) begin
            r_line[r_count] <= sdr_q;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_ack   = r_rd_ack;
    assign busy     = r_busy;
    assign sdr_addr = r_sdr_addr;
    assign sdr_req  = r_sdr_req;

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_burst_reader
//  Description : Self-checking bench for rom_burst_reader. An SDRAM image is
//                kept as a sparse word map; the cache is modelled as "which
//                line start is currently held and valid".
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_burst_reader;

    localparam logic [24:0] TB_BASE  = 25'h1FFFFF8;
    localparam int          TB_BURST = 4;
    localparam int          OFF      = $clog2(TB_BURST) + 1;

    logic        sys_clk;
    logic        reset_n;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_ack;
    logic        flush;
    logic        busy;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy;
    logic [15:0] sdr_q;

    int          n_pass;
    int          n_checks;

    logic [15:0] mem [logic [23:0]];
    logic        m_valid;
    logic [24:0] m_ls;

    rom_burst_reader #(
        .BASE_ADDR (TB_BASE),
        .BURST     (TB_BURST)
    ) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack),
        .flush    (flush),
        .busy     (busy),
        .sdr_addr (sdr_addr),
        .sdr_req  (sdr_req),
        .sdr_rdy  (sdr_rdy),
        .sdr_q    (sdr_q)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [15:0] mem_word(input logic [23:0] wa);
        if (!mem.exists(wa)) mem[wa] = 16'($urandom);
        return mem[wa];
    endfunction

    function automatic logic [24:0] full_of(input logic [24:0] a);
        return TB_BASE + a;
    endfunction

    function automatic logic [24:0] line_start(input logic [24:0] full);
        logic [24:0] mask;
        mask = 25'((1 << OFF) - 1);
        return full & ~mask;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Return one line of words in order with random gaps; optional flush / rd_req drop at word k
    task automatic serve_fill(input logic [24:0] ls, input int flush_at, input int drop_at);
        for (int k = 0; k < TB_BURST; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("busy_fill", {31'd0, busy}, 32'd1);
                chk("sdr_req_hold", {31'd0, sdr_req}, {31'd0, k == 0});
            end
            sdr_rdy = 1'b1;
            sdr_q   = mem_word(ls[24:1] + 24'(k));
            if (k == flush_at) flush = 1'b1;
            if (k == drop_at)  rd_req = 1'b0;
            tick();
            sdr_rdy = 1'b0;
            flush   = 1'b0;
            if (k == 0) chk("sdr_req_drop", {31'd0, sdr_req}, 32'd0);
        end
        chk("ack_early", {31'd0, rd_ack}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        // A stray word after the line is complete must be ignored
        sdr_rdy = 1'b1;
        sdr_q   = 16'hDEAD;
        tick();
        sdr_rdy = 1'b0;
    endtask

    task automatic do_read(input logic [24:0] a, input int flush_at, input int drop_at);
        logic [24:0] full;
        logic [24:0] ls;
        logic        hit;
        full = full_of(a);
        ls   = line_start(full);
        hit  = m_valid && (m_ls == ls);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        if (hit) begin
            chk("hit_ack", {31'd0, rd_ack}, 32'd1);
            chk("hit_data", {16'd0, rd_data}, {16'd0, mem_word(full[24:1])});
            chk("hit_no_req", {31'd0, sdr_req}, 32'd0);
        end else begin
            chk("miss_req", {31'd0, sdr_req}, 32'd1);
            chk("miss_addr", {7'd0, sdr_addr}, {7'd0, ls});
            chk("miss_busy", {31'd0, busy}, 32'd1);
            chk("miss_no_ack", {31'd0, rd_ack}, 32'd0);
            serve_fill(ls, flush_at, drop_at);
            if (drop_at < 0) begin
                chk("miss_ack", {31'd0, rd_ack}, 32'd1);
                chk("miss_data", {16'd0, rd_data}, {16'd0, mem_word(full[24:1])});
            end else begin
                chk("drop_no_ack", {31'd0, rd_ack}, 32'd0);
            end
            m_valid = (flush_at < 0);
            m_ls    = ls;
        end
        rd_req = 1'b0;
        tick();
        chk("ack_one_cycle", {31'd0, rd_ack}, 32'd0);
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // Flush models a new ROM download, so the SDRAM image changes too
        mem.delete();
        m_valid = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        m_valid  = 1'b0;
        m_ls     = 25'h0;
        reset_n  = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = 25'h0;
        flush    = 1'b0;
        sdr_rdy  = 1'b0;
        sdr_q    = 16'h0;
        tick();
        tick();
        chk("rst_ack", {31'd0, rd_ack}, 32'd0);
        chk("rst_data", {16'd0, rd_data}, 32'd0);
        chk("rst_req", {31'd0, sdr_req}, 32'd0);
        chk("rst_addr", {7'd0, sdr_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Cold miss on a wrapped address: base 0x1FFFFF8 + 0x10 -> line at 0x0000008
        for (int k = 0; k < TB_BURST; k++) mem[24'd4 + 24'(k)] = 16'h00A0 + 16'(k);
        do_read(25'h10, -1, -1);
        chk("wrap_line", {7'd0, m_ls}, 32'h8);
        chk("cold_value", {16'd0, mem_word(24'd4)}, 32'hA0);
        do_read(25'h16, -1, -1);
        chk("hit_value", {16'd0, rd_data}, 32'hA3);

        // Flush while idle, then the same address must refetch fresh data
        flush_pulse();
        do_read(25'h10, -1, -1);

        // Flush during a refill: request still served, line not kept
        do_read(25'h40, 2, -1);
        do_read(25'h42, -1, -1);

        // Client drops rd_req mid-refill: no ack, but the line becomes valid
        do_read(25'h80, -1, 1);
        do_read(25'h86, -1, -1);

        // Reset after two returned words abandons the refill
        rd_req  = 1'b1;
        rd_addr = 25'h10;
        tick();
        for (int k = 0; k < 2; k++) begin
            sdr_rdy = 1'b1;
            sdr_q   = 16'($urandom);
            tick();
            sdr_rdy = 1'b0;
        end
        reset_n = 1'b0;
        rd_req  = 1'b0;
        tick();
        reset_n = 1'b1;
        m_valid = 1'b0;
        chk("rstfill_req", {31'd0, sdr_req}, 32'd0);
        chk("rstfill_busy", {31'd0, busy}, 32'd0);
        chk("rstfill_data", {16'd0, rd_data}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            sdr_rdy = 1'b1;
            sdr_q   = 16'($urandom);
            tick();
            sdr_rdy = 1'b0;
            chk("idle_rdy_busy", {31'd0, busy}, 32'd0);
            chk("idle_rdy_ack", {31'd0, rd_ack}, 32'd0);
        end
        do_read(25'h10, -1, -1);

        // Random reads over a handful of lines, with occasional flushes
        for (int i = 0; i < 40; i++) begin
            int          r;
            logic [24:0] a;
            r = $urandom_range(0, 9);
            a = 25'(($urandom_range(0, 5) << OFF) | ($urandom_range(0, TB_BURST - 1) << 1)
                    | $urandom_range(0, 1));
            if (r == 0) begin
                flush_pulse();
                chk("flush_idle_busy", {31'd0, busy}, 32'd0);
            end else if (r == 1) begin
                do_read(a, int'($urandom_range(0, TB_BURST - 1)), -1);
            end else begin
                do_read(a, -1, -1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
